// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Pipeline hazard controller that sits beside the decode stage of the
//   5-stage RV32I core. It tracks in-flight destination registers, interlocks
//   decode on RAW/WAW hazards, squashes wrong-path work after an EX redirect
//   and counts stall cycles.
//
//   Build option: define HAZARD_FWD_EN when the EX/MEM->EX and WB->EX bypasses
//   exist. The only interlock is then load-use, and the scoreboard register is
//   not built (sb_busy reads 0).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   id_valid                 IF/ID holds a real instruction
//   id_rs1/id_rs2            source indices; id_use_rs1/2 qualify them
//   id_rd, id_regwrite       destination of the ID instruction
//   id_is_load               ID instruction is a load
//   ex_redirect              taken branch/jump resolved in EX (1-cycle pulse)
//   wb_regwrite, wb_rd       writeback port activity
//   stall_cnt_clr            synchronous clear of stall_cnt
//   stall_f/stall_d          hold PC / hold IF/ID
//   flush_d/flush_e          clear IF/ID / bubble into ID/EX
//   issue                    ID instruction advances into EX this cycle
//   sb_busy[31:0]            pending-write bits, bit 0 always 0
//   stall_cnt[15:0]          saturating count of stall_d cycles
//   dbg[7:0]                 {state[1:0], ex_ld_valid, ex_ld_rd[4:0]}
//
// Handshake: there is no valid/ready pair here. issue is the "accept" of the
// instruction offered by id_valid; an instruction is consumed only in a cycle
// where issue=1, otherwise it either waits (stall_d) or is discarded (flush_d).
module hazard_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_regwrite,
  input  logic        id_is_load,
  input  logic        ex_redirect,
  input  logic        wb_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic        stall_cnt_clr,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic        issue,
  output logic [31:0] sb_busy,
  output logic [15:0] stall_cnt,
  output logic [7:0]  dbg
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    FLUSH = 2'b01
  } state_t;

  state_t      state_q, state_d;
  logic        ex_ld_valid_q, ex_ld_valid_d;
  logic [4:0]  ex_ld_rd_q, ex_ld_rd_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        hz;
  logic        run;
  logic        stall_w;
  logic        issue_w;

  assign run = (state_q == RUN);

`ifdef HAZARD_FWD_EN
  // With bypassing only a load result still in EX is unavailable to the
  // instruction in ID, so that is the only case that must wait (one cycle).
  assign hz = ex_ld_valid_q && (ex_ld_rd_q != 5'd0) &&
              ((id_use_rs1 && (id_rs1 == ex_ld_rd_q)) ||
               (id_use_rs2 && (id_rs2 == ex_ld_rd_q)));
  assign sb_busy = 32'd0;

  logic unused_fwd_inputs;
  assign unused_fwd_inputs = ^{wb_regwrite, wb_rd, id_regwrite};
`else
  logic [31:0] sb_q, sb_d;

  assign hz = (id_use_rs1  && sb_q[id_rs1]) ||
              (id_use_rs2  && sb_q[id_rs2]) ||
              (id_regwrite && sb_q[id_rd]);

  // Clear first so that a same-cycle set of the same index wins.
  always_comb begin
    sb_d = sb_q;
    if (wb_regwrite && (wb_rd != 5'd0)) sb_d[wb_rd] = 1'b0;
    if (issue_w && id_regwrite && (id_rd != 5'd0)) sb_d[id_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb_q <= 32'd0;
    else     sb_q <= sb_d;
  end

  assign sb_busy = sb_q;
`endif

  // Redirect beats stall: a wrong-path instruction neither stalls nor issues.
  // All control outputs are forced low while reset is held.
  always_comb begin
    stall_w = !rst && id_valid && hz && !ex_redirect && run;
    issue_w = !rst && id_valid && !stall_w && !ex_redirect && run;
  end

  assign stall_f = stall_w;
  assign stall_d = stall_w;
  assign issue   = issue_w;
  assign flush_d = !rst && ex_redirect;
  assign flush_e = !rst && (ex_redirect || stall_w || !run);

  // FSM next state: any redirect (re)enters FLUSH, otherwise back to RUN.
  always_comb begin
    state_d = RUN;
    case (state_q)
      RUN:     if (ex_redirect) state_d = FLUSH;
      FLUSH:   if (ex_redirect) state_d = FLUSH;
      default: state_d = RUN;
    endcase
  end

  // Load tracking and stall counter next state.
  always_comb begin
    ex_ld_valid_d = 1'b0;
    ex_ld_rd_d    = 5'd0;
    if (issue_w) begin
      ex_ld_valid_d = id_is_load;
      ex_ld_rd_d    = id_rd;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_cnt_clr)
      stall_cnt_d = 16'd0;
    else if (stall_w && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      ex_ld_valid_q <= 1'b0;
      ex_ld_rd_q    <= 5'd0;
      stall_cnt_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      ex_ld_valid_q <= ex_ld_valid_d;
      ex_ld_rd_q    <= ex_ld_rd_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign dbg       = {state_q, ex_ld_valid_q, ex_ld_rd_q};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard
//   Self-checking bench for hazard_scoreboard. A behavioural model (set of
//   pending registers, a "previous cycle redirected" flag, an integer stall
//   counter and the last issued load) predicts every output each cycle.
//   Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
  logic        ex_redirect, wb_regwrite, stall_cnt_clr;
  logic        stall_f, stall_d, flush_d, flush_e, issue;
  logic [31:0] sb_busy;
  logic [15:0] stall_cnt;
  logic [7:0]  dbg;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
    .stall_cnt_clr(stall_cnt_clr),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .flush_e(flush_e), .issue(issue), .sb_busy(sb_busy),
    .stall_cnt(stall_cnt), .dbg(dbg)
  );

  // ---------------- reference model ----------------
  bit busy_m [32];
  bit flush_m;
  int cnt_m;
  int ld_m;
  logic last_stall, last_issue;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] busy_vec();
    logic [31:0] v;
    v = 32'd0;
`ifndef HAZARD_FWD_EN
    for (int i = 1; i < 32; i++) v[i] = busy_m[i];
`endif
    return v;
  endfunction

  function automatic bit model_hz();
`ifdef HAZARD_FWD_EN
    return (ld_m != 0) && ((id_use_rs1 && (int'(id_rs1) == ld_m)) ||
                           (id_use_rs2 && (int'(id_rs2) == ld_m)));
`else
    return (id_use_rs1 && busy_m[id_rs1]) || (id_use_rs2 && busy_m[id_rs2]) ||
           (id_regwrite && busy_m[id_rd]);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    flush_m = 1'b0;
    cnt_m   = 0;
    ld_m    = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    id_rd = 0; id_regwrite = 0; id_is_load = 0; ex_redirect = 0;
    wb_regwrite = 0; wb_rd = 0; stall_cnt_clr = 0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic rw, input logic ld);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_regwrite = rw; id_is_load = ld;
  endtask

  // Called at a falling edge with inputs already driven; checks this cycle,
  // advances the model over the rising edge and returns at the next falling edge.
  task automatic cycle();
    bit st, is, fe;
    #1;
    st = id_valid && model_hz() && !ex_redirect && !flush_m;
    is = id_valid && !st && !ex_redirect && !flush_m;
    fe = ex_redirect || st || flush_m;
    exp_q.push_back({27'd0, st, st, ex_redirect, fe, is});
    check_val("ctrl{stall_f,stall_d,flush_d,flush_e,issue}",
              {27'd0, stall_f, stall_d, flush_d, flush_e, issue}, exp_q.pop_front());
    check_val("sb_busy", sb_busy, busy_vec());
    check_val("stall_cnt", {16'd0, stall_cnt}, cnt_m);
    last_stall = stall_d;
    last_issue = issue;
    @(posedge clk);
    if (stall_cnt_clr) cnt_m = 0;
    else if (st && cnt_m < 65535) cnt_m++;
    if (wb_regwrite && wb_rd != 0) busy_m[wb_rd] = 1'b0;
    if (is && id_regwrite && id_rd != 0) busy_m[id_rd] = 1'b1;
    ld_m    = (is && id_is_load) ? int'(id_rd) : 0;
    flush_m = ex_redirect;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctrl"}, {27'd0, stall_f, stall_d, flush_d, flush_e, issue}, 32'd0);
    check_val({tag, "_sb_busy"}, sb_busy, 32'd0);
    check_val({tag, "_stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
    check_val({tag, "_dbg"}, {24'd0, dbg}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int stalls;
    int pick_q[$];
    rst = 1'b1;
    idle();
    model_reset();
    // Drive inputs that would otherwise assert outputs while reset is held.
    set_id(5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
    ex_redirect = 1;
    @(negedge clk);
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    idle();
    stall_cnt_clr = 1;
    cycle();
    idle();

`ifndef HAZARD_FWD_EN
    // RAW: addi x5 then add x6,x5,x1 -> 3 stalls, issue after x5 writeback.
    set_id(5'd0, 5'd0, 0, 0, 5'd5, 1, 0);
    cycle();
    set_id(5'd5, 5'd1, 1, 1, 5'd6, 1, 0);
    stalls = 0;
    cycle(); stalls += int'(last_stall);
    cycle(); stalls += int'(last_stall);
    wb_regwrite = 1; wb_rd = 5'd5;
    cycle(); stalls += int'(last_stall);
    wb_regwrite = 0;
    cycle();
    check_val("raw_issue_after_wb", {31'd0, last_issue}, 32'd1);
    check_val("raw_stall_cycles", stalls, 32'd3);
    check_val("raw_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    idle();
    wb_regwrite = 1; wb_rd = 5'd6;
    cycle();
    idle();

    // Redirect during a stall: x9 busy, consumer rd=x10 stalled then redirected.
    set_id(5'd0, 5'd0, 0, 0, 5'd9, 1, 0);
    cycle();
    set_id(5'd9, 5'd0, 1, 0, 5'd10, 1, 0);
    cycle();
    check_val("redir_pre_stall", {31'd0, last_stall}, 32'd1);
    ex_redirect = 1;
    cycle();
    check_val("redir_stall_d", {31'd0, last_stall}, 32'd0);
    check_val("redir_issue", {31'd0, last_issue}, 32'd0);
    ex_redirect = 0;
    set_id(5'd0, 5'd0, 0, 0, 5'd11, 1, 0);
    cycle();
    check_val("flush_state_issue", {31'd0, last_issue}, 32'd0);
    check_val("wrong_path_rd_bits", {30'd0, sb_busy[11], sb_busy[10]}, 32'd0);
    // Back-to-back redirects.
    ex_redirect = 1;
    cycle();
    cycle();
    ex_redirect = 0;
    cycle();
    idle();
    wb_regwrite = 1; wb_rd = 5'd9;
    cycle();

    // Set/clear collision on x7: set wins.
    set_id(5'd0, 5'd0, 0, 0, 5'd7, 1, 0);
    wb_regwrite = 1; wb_rd = 5'd7;
    cycle();
    idle();
    #1;
    check_val("collision_sb7", {31'd0, sb_busy[7]}, 32'd1);
    wb_regwrite = 1; wb_rd = 5'd7;
    cycle();
    idle();

    // x0 producer never blocks a consumer of x0.
    set_id(5'd0, 5'd0, 0, 0, 5'd0, 1, 0);
    cycle();
    set_id(5'd0, 5'd0, 1, 1, 5'd0, 1, 0);
    cycle();
    check_val("x0_no_stall", {30'd0, last_stall, last_issue}, 32'd1);
    idle();
`endif

    // Reset mid-stall with x5 pending.
    set_id(5'd0, 5'd0, 0, 0, 5'd5, 1, 0);
    cycle();
    set_id(5'd5, 5'd0, 1, 0, 5'd8, 1, 0);
    cycle();
`ifndef HAZARD_FWD_EN
    #2;
    check_val("pre_reset_sb_busy", sb_busy, 32'h0000_0020);
`endif
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk);
    #1;
    check_all_zero("mid_rst_edge");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cycle();
    check_val("post_rst_issue", {31'd0, last_issue}, 32'd1);
    idle();
    wb_regwrite = 1; wb_rd = 5'd8;
    cycle();
    idle();

`ifndef HAZARD_FWD_EN
    // Saturation: hold a hazard on x12 for 70000 cycles, then clear.
    set_id(5'd0, 5'd0, 0, 0, 5'd12, 1, 0);
    cycle();
    set_id(5'd12, 5'd0, 1, 0, 5'd13, 1, 0);
    cycle();
    repeat (70000) @(posedge clk);
    cnt_m = (cnt_m + 70000 > 65535) ? 65535 : cnt_m + 70000;
    @(negedge clk);
    #1;
    check_val("sat_stall_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
    stall_cnt_clr = 1;
    cycle();
    stall_cnt_clr = 0;
    #1;
    check_val("sat_clr", {16'd0, stall_cnt}, 32'd0);
    idle();
    wb_regwrite = 1; wb_rd = 5'd12;
    cycle();
    idle();
`else
    // Load-use costs exactly one stall; ALU producer costs none.
    set_id(5'd0, 5'd0, 0, 0, 5'd3, 1, 1);
    cycle();
    set_id(5'd3, 5'd3, 1, 1, 5'd4, 1, 0);
    stalls = 0;
    cycle(); stalls += int'(last_stall);
    cycle(); stalls += int'(last_stall);
    check_val("fwd_load_use_stalls", stalls, 32'd1);
    check_val("fwd_load_use_issue", {31'd0, last_issue}, 32'd1);
    set_id(5'd0, 5'd0, 0, 0, 5'd3, 1, 0);
    cycle();
    set_id(5'd3, 5'd3, 1, 1, 5'd4, 1, 0);
    cycle();
    check_val("fwd_alu_no_stall", {31'd0, last_stall}, 32'd0);
    check_val("fwd_sb_busy_zero", sb_busy, 32'd0);
    idle();
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 9) < 8) begin
        set_id(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      end
      ex_redirect = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) < 4) begin
        pick_q.delete();
        for (int i = 1; i < 32; i++) if (busy_m[i]) pick_q.push_back(i);
        wb_regwrite = 1;
        wb_rd = (pick_q.size() > 0) ? 5'(pick_q[$urandom_range(0, pick_q.size() - 1)])
                                    : 5'($urandom_range(0, 31));
      end
      stall_cnt_clr = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
